// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: MIPS opcode constants, instruction field positions
// and the decode-stage skid-buffer state encoding.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SA_MSB  = 10;
  localparam int SA_LSB  = 6;
  localparam int FUN_MSB = 5;
  localparam int FUN_LSB = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

endpackage

// File: rtl/decode_fields.sv
// Pure combinational MIPS field split, immediate extension and jump/branch
// target computation from one {instr, pc} pair.
module decode_fields
  import cpu_defs::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic [5:0]      o_op,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_sa,
  output logic [5:0]      o_fun,
  output logic [15:0]     o_imm16,
  output logic [25:0]     o_imm26,
  output logic [31:0]     o_imm_ext,
  output logic            o_is_rtype,
  output logic [PC_W-1:0] o_jump_target,
  output logic [PC_W-1:0] o_branch_target
);

  logic [PC_W-1:0] w_pc4;
  logic [PC_W-1:0] w_boff;

  assign o_op       = i_instr[OP_MSB:OP_LSB];
  assign o_rs       = i_instr[RS_MSB:RS_LSB];
  assign o_rt       = i_instr[RT_MSB:RT_LSB];
  assign o_rd       = i_instr[RD_MSB:RD_LSB];
  assign o_sa       = i_instr[SA_MSB:SA_LSB];
  assign o_fun      = i_instr[FUN_MSB:FUN_LSB];
  assign o_imm16    = i_instr[15:0];
  assign o_imm26    = i_instr[25:0];
  assign o_is_rtype = (o_op == OP_RTYPE);

  always_comb begin
    o_imm_ext = {{16{o_imm16[15]}}, o_imm16};
    case (o_op)
      OP_ANDI, OP_ORI, OP_XORI: o_imm_ext = {16'h0000, o_imm16};
      OP_LUI:                   o_imm_ext = {o_imm16, 16'h0000};
      default: ;
    endcase
  end

  // All PC arithmetic is modulo 2^PC_W; carries out of the top are dropped.
  assign w_pc4           = i_pc + PC_W'(4);
  assign w_boff          = {{(PC_W-18){o_imm16[15]}}, o_imm16, 2'b00};
  assign o_branch_target = w_pc4 + w_boff;

  generate
    if (PC_W > 28) begin : g_jt_wide
      assign o_jump_target = {w_pc4[PC_W-1:28], o_imm26, 2'b00};
    end else begin : g_jt_narrow
      assign o_jump_target = {o_imm26, 2'b00};
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Registered IF/ID stage: valid/ready input, 2-entry skid buffer (or single
// register), combinational decode of the head entry with zeroed idle outputs.
module decode_stage
  import cpu_defs::*;
#(
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      op,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      sa,
  output logic [5:0]      fun,
  output logic [15:0]     imm16,
  output logic [25:0]     imm26,
  output logic [31:0]     imm_ext,
  output logic            is_rtype,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] branch_target
);

  skid_st_e        r_state, w_state_nxt;
  logic [31:0]     r_h_instr, r_s_instr;
  logic [PC_W-1:0] r_h_pc, r_s_pc;
  logic            w_accept, w_retire;
  logic            w_ld_head_in, w_ld_head_skid, w_ld_skid;

  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_retire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Flush wins over accept and retire; load strobes stay low so nothing new lands.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_head_in   = 1'b0;
    w_ld_head_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) begin
          w_state_nxt  = ST_ONE;
          w_ld_head_in = 1'b1;
        end
        ST_ONE: begin
          if (w_accept && w_retire) begin
            w_ld_head_in = 1'b1;
          end else if (w_accept) begin
            if (SKID != 0) begin
              w_state_nxt = ST_FULL;
              w_ld_skid   = 1'b1;
            end
          end else if (w_retire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: if (w_retire) begin
          w_state_nxt    = ST_ONE;
          w_ld_head_skid = 1'b1;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_instr <= '0;
      r_h_pc    <= '0;
      r_s_instr <= '0;
      r_s_pc    <= '0;
    end else begin
      if (w_ld_head_in) begin
        r_h_instr <= in_instr;
        r_h_pc    <= in_pc;
      end else if (w_ld_head_skid) begin
        r_h_instr <= r_s_instr;
        r_h_pc    <= r_s_pc;
      end
      if (w_ld_skid) begin
        r_s_instr <= in_instr;
        r_s_pc    <= in_pc;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;
      always_ff @(posedge clk) begin
        if (rst) r_in_ready <= 1'b1;
        else     r_in_ready <= (w_state_nxt != ST_FULL);
      end
      assign in_ready = r_in_ready;
    end else begin : g_single
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  logic [5:0]      w_op, w_fun;
  logic [4:0]      w_rs, w_rt, w_rd, w_sa;
  logic [15:0]     w_imm16;
  logic [25:0]     w_imm26;
  logic [31:0]     w_imm_ext;
  logic            w_is_rtype;
  logic [PC_W-1:0] w_jt, w_bt;

  decode_fields #(.PC_W(PC_W)) u_fields (
    .i_instr         (r_h_instr),
    .i_pc            (r_h_pc),
    .o_op            (w_op),
    .o_rs            (w_rs),
    .o_rt            (w_rt),
    .o_rd            (w_rd),
    .o_sa            (w_sa),
    .o_fun           (w_fun),
    .o_imm16         (w_imm16),
    .o_imm26         (w_imm26),
    .o_imm_ext       (w_imm_ext),
    .o_is_rtype      (w_is_rtype),
    .o_jump_target   (w_jt),
    .o_branch_target (w_bt)
  );

  // Idle outputs read as zero rather than exposing a stale head entry.
  assign op            = out_valid ? w_op       : '0;
  assign rs            = out_valid ? w_rs       : '0;
  assign rt            = out_valid ? w_rt       : '0;
  assign rd            = out_valid ? w_rd       : '0;
  assign sa            = out_valid ? w_sa       : '0;
  assign fun           = out_valid ? w_fun      : '0;
  assign imm16         = out_valid ? w_imm16    : '0;
  assign imm26         = out_valid ? w_imm26    : '0;
  assign imm_ext       = out_valid ? w_imm_ext  : '0;
  assign is_rtype      = out_valid ? w_is_rtype : 1'b0;
  assign pc_out        = out_valid ? r_h_pc     : '0;
  assign jump_target   = out_valid ? w_jt       : '0;
  assign branch_target = out_valid ? w_bt       : '0;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered IF/ID decode stage for the pipelined CPU generation. Replaces the purely combinational field splitter.
- Accepts a fetched instruction plus its PC over a valid/ready handshake and holds it in a 2-entry skid buffer.
- Presents the MIPS-format fields, extended immediates and precomputed jump/branch targets from the head entry to the execute stage.
- Supports flush (branch mispredict or jump) and full backpressure without bubbles.

Parameters:
- PC_W, 32, width of PC and of the computed targets (>= 28).
- SKID, 1, 1 = 2-entry skid buffer (full throughput); 0 = single register, in_ready = !valid | out_ready (combinational).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held instructions this cycle
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  address of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  execute stage accepts head
- op  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- sa  out  5  instr[10:6]
- fun  out  6  instr[5:0]
- imm16  out  16  instr[15:0]
- imm26  out  26  instr[25:0]
- imm_ext  out  32  zero-ext of imm16 for op 0x0C/0x0D/0x0E; {imm16,16'h0} for op 0x0F; sign-ext otherwise
- is_rtype  out  1  op == 6'h00
- pc_out  out  PC_W  PC of head entry
- jump_target  out  PC_W  {pc4[PC_W-1:28], imm26, 2'b00}, where pc4 = pc_out + 4
- branch_target  out  PC_W  pc4 + (sign-ext imm16 << 2), truncated mod 2^PC_W

Behaviour:
- Reset: both entries invalid; out_valid = 0; in_ready = 1 in the cycle after reset. All field, PC and target outputs = 0 while out_valid = 0. Outputs are forced to zero, never stale.
- Transfer rules:
  - Accept when in_valid & in_ready.
  - Retire when out_valid & out_ready.
  - Accepted data appears on the outputs the next cycle (latency 1).
- SKID = 1:
  - in_ready is a register: high iff fewer than 2 entries will be held after this edge's update.
  - States: EMPTY, ONE, FULL.
    - EMPTY + accept → ONE.
    - ONE + accept & retire → ONE (new entry becomes head).
    - ONE + accept & !retire → FULL.
    - ONE + retire only → EMPTY.
    - FULL + retire → ONE (skid entry promoted to head).
    - FULL ignores in_valid.
  - Order is strictly FIFO.
- SKID = 0:
  - Single entry.
  - Accept & retire in the same cycle replaces the entry.
- Flush:
  - All entries become invalid at the edge; out_valid = 0 next cycle.
  - Any same-cycle accept is dropped; flush has priority over accept and retire.
  - in_ready is 1 the following cycle.
  - A same-cycle retire still counts as completed for the downstream stage, since it sampled the data.
- rst has priority over flush. Reset mid-transfer discards everything; no partial state survives.
- Outputs hold stable while out_valid & !out_ready. Decode is combinational from the head register only; no in_* input reaches the outputs combinationally.
- PC arithmetic wraps mod 2^PC_W. A negative branch offset below 0 wraps.
- Invalid opcodes pass through unchanged; illegal-op detection belongs to the controller.

Decomposition:
- Shared package (cpu_defs):
  - opcode constants OP_RTYPE=6'h00, OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_XORI=6'h0E, OP_LUI=6'h0F
  - field bit-position localparams
  - the 3-state skid-state encoding
- One natural sub-module: decode_fields, a pure combinational split/extend/target computation from {instr, pc}. It is instantiated once on the head entry and is reusable by the controller.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles → out_valid=0, all outputs 0.
  - First cycle after rst drops → in_ready=1.
- Field/immediate check:
  - in_instr=32'h2128FFFC (addi), pc=32'h00400000, out_ready=1 → next cycle: op=0x08, rs=9, rt=8, imm_ext=32'hFFFFFFFC, branch_target=32'h003FFFF4, is_rtype=0.
  - Then ori 32'h3508FFFF → imm_ext=32'h0000FFFF.
  - Then lui 32'h3C081234 → imm_ext=32'h12340000.
- Jump target:
  - instr=32'h08100004, pc=32'h1000_0000 → jump_target=32'h10400010.
- Backpressure (SKID=1):
  - out_ready=0, stream 3 instructions A,B,C with in_valid=1 → A, B accepted, in_ready=0, C held by source.
  - Raise out_ready → A, B, C emitted in order on consecutive cycles, no bubble.
- Flush while FULL with simultaneous in_valid:
  - Next cycle out_valid=0, new instr not captured, in_ready=1.
  - Following accept emits normally.
- Throughput:
  - in_valid=out_ready=1 for 100 sequential PCs → 100 outputs in 100 consecutive cycles, matching order and PCs.
